// File: rtl/wash_pkg.sv
// Shared definitions for the parametrised washing-machine sequencer:
// one-hot state encodings, error_code bit positions, mode codes and duration scaling.
package wash_pkg;

  typedef enum logic [8:0] {
    ST_IDLE     = 9'h001,
    ST_READY    = 9'h002,
    ST_FILL     = 9'h004,
    ST_WASH     = 9'h008,
    ST_RINSE    = 9'h010,
    ST_SPIN     = 9'h020,
    ST_DRAIN    = 9'h040,
    ST_COMPLETE = 9'h080,
    ST_ERROR    = 9'h100
  } state_t;

  localparam int ERR_MOTOR    = 0;
  localparam int ERR_PRESSURE = 1;
  localparam int ERR_SENSOR   = 2;
  localparam int ERR_DOOR     = 3;

  localparam logic [1:0] MODE_NORMAL = 2'd0;
  localparam logic [1:0] MODE_QUICK  = 2'd1;
  localparam logic [1:0] MODE_HEAVY  = 2'd2;

  // Quick halves (never below 1), heavy doubles; everything saturates at max_val.
  function automatic logic [31:0] scale_ticks(input logic [31:0] base,
                                              input logic [1:0]  mode,
                                              input logic [31:0] max_val);
    logic [32:0] dbl;
    logic [31:0] half;
    dbl  = {base, 1'b0};
    half = base >> 1;
    scale_ticks = (base > max_val) ? max_val : base;
    case (mode)
      MODE_QUICK: begin
        if (half == 32'd0)      scale_ticks = 32'd1;
        else if (half > max_val) scale_ticks = max_val;
        else                     scale_ticks = half;
      end
      MODE_HEAVY: scale_ticks = (dbl > {1'b0, max_val}) ? max_val : dbl[31:0];
      default: ;
    endcase
  endfunction

endpackage

// File: rtl/wash_phase_timer.sv
// Phase down-counter: loads a duration on phase entry, counts to zero, flags the last tick.
module wash_phase_timer #(
  parameter int TIMER_W = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  input  logic               hold,
  output logic [TIMER_W-1:0] count,
  output logic               done
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (!hold && count != '0) begin
      count <= count - TIMER_W'(1);
    end
  end

  assign done = (count == TIMER_W'(1));

endmodule

// File: rtl/wash_sequencer_param.sv
// Parametrised washing-machine cycle controller with timed phases, modes and rinse passes.
// Optional pause support is enabled by defining WASH_SEQ_PAUSE_EN.
module wash_sequencer_param
  import wash_pkg::*;
#(
  parameter int TIMER_W     = 8,
  parameter int FILL_TICKS  = 4,
  parameter int WASH_TICKS  = 8,
  parameter int RINSE_TICKS = 6,
  parameter int SPIN_TICKS  = 5,
  parameter int DRAIN_TICKS = 3,
  parameter int MAX_RINSES  = 3,
  parameter int RINSE_W     = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               sig_door_closed,
  input  logic               sig_start_button,
  input  logic               sig_cancel_button,
  input  logic               sig_pause_button,
  input  logic               sig_Motor_Failure,
  input  logic               sig_Low_Water_Pressure,
  input  logic               sig_Sensor_Malfunction,
  input  logic [1:0]         mode,
  input  logic [RINSE_W-1:0] rinse_sel,
  output logic [8:0]         state,
  output logic               complete,
  output logic               water_filling,
  output logic               door_locked,
  output logic               motor_on,
  output logic               drain_pump,
  output logic [3:0]         error_code,
  output logic [RINSE_W-1:0] rinse_index,
  output logic [TIMER_W-1:0] ticks_left
);

  localparam logic [31:0] TMAX = (32'd1 << TIMER_W) - 32'd1;

  state_t             state_q, state_nx;
  logic               start_prev, start_edge, raw_fault, is_locked, paused, expired;
  logic [3:0]         fault_bits, err_nx;
  logic [1:0]         mode_q, mode_nx;
  logic [RINSE_W-1:0] tgt_q, tgt_nx, rinse_nx, done_cnt;
  logic               wash_done_q, wash_done_nx;
  logic               after_rinse_q, after_rinse_nx;
  logic               abort_q, abort_nx;
  logic               tmr_load, tmr_done;
  logic [TIMER_W-1:0] tmr_val;

  function automatic logic [TIMER_W-1:0] phase_ticks(input state_t s, input logic [1:0] m);
    logic [31:0] base;
    logic [31:0] full;
    case (s)
      ST_FILL:  base = 32'(FILL_TICKS);
      ST_WASH:  base = 32'(WASH_TICKS);
      ST_RINSE: base = 32'(RINSE_TICKS);
      ST_SPIN:  base = 32'(SPIN_TICKS);
      ST_DRAIN: base = 32'(DRAIN_TICKS);
      default:  base = 32'd0;
    endcase
    full = (base == 32'd0) ? 32'd0 : scale_ticks(base, m, TMAX);
    return full[TIMER_W-1:0];
  endfunction

  assign start_edge = sig_start_button && !start_prev;
  assign raw_fault  = sig_Motor_Failure || sig_Low_Water_Pressure || sig_Sensor_Malfunction;
  assign is_locked  = state_q inside {ST_FILL, ST_WASH, ST_RINSE, ST_SPIN, ST_DRAIN};

`ifdef WASH_SEQ_PAUSE_EN
  assign paused = sig_pause_button && is_locked;
`else
  logic unused_pause;
  assign unused_pause = sig_pause_button;
  assign paused       = 1'b0;
`endif

  assign expired = tmr_done && !paused;

  always_comb begin
    fault_bits               = '0;
    fault_bits[ERR_MOTOR]    = sig_Motor_Failure && (state_q inside {ST_WASH, ST_RINSE, ST_SPIN});
    fault_bits[ERR_PRESSURE] = sig_Low_Water_Pressure && (state_q == ST_FILL);
    fault_bits[ERR_SENSOR]   = sig_Sensor_Malfunction && is_locked;
    fault_bits[ERR_DOOR]     = !sig_door_closed && is_locked;
  end

  always_comb begin
    state_nx       = state_q;
    mode_nx        = mode_q;
    tgt_nx         = tgt_q;
    rinse_nx       = rinse_index;
    wash_done_nx   = wash_done_q;
    after_rinse_nx = after_rinse_q;
    abort_nx       = abort_q;
    err_nx         = error_code;
    done_cnt       = rinse_index + RINSE_W'(after_rinse_q);

    if (|fault_bits) begin
      state_nx = ST_ERROR;
      err_nx   = error_code | fault_bits;
      rinse_nx = '0;
      abort_nx = 1'b0;
    end else if (sig_cancel_button && (state_q inside {ST_FILL, ST_WASH, ST_RINSE, ST_SPIN})) begin
      state_nx = ST_DRAIN;
      abort_nx = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: if (sig_door_closed) state_nx = ST_READY;
        ST_READY: begin
          if (!sig_door_closed || sig_cancel_button) begin
            state_nx = ST_IDLE;
          end else if (start_edge && !raw_fault) begin
            state_nx       = ST_FILL;
            mode_nx        = mode;
            tgt_nx         = (32'(rinse_sel) > 32'(MAX_RINSES)) ? RINSE_W'(MAX_RINSES) : rinse_sel;
            rinse_nx       = '0;
            wash_done_nx   = 1'b0;
            after_rinse_nx = 1'b0;
            abort_nx       = 1'b0;
            err_nx         = '0;
          end
        end
        ST_FILL: if (expired) state_nx = wash_done_q ? ST_RINSE : ST_WASH;
        ST_WASH: begin
          if (expired) begin
            state_nx       = ST_DRAIN;
            wash_done_nx   = 1'b1;
            after_rinse_nx = 1'b0;
          end
        end
        ST_RINSE: begin
          if (expired) begin
            state_nx       = ST_DRAIN;
            after_rinse_nx = 1'b1;
          end
        end
        ST_SPIN: if (expired) state_nx = ST_COMPLETE;
        ST_DRAIN: begin
          if (expired) begin
            if (abort_q) begin
              state_nx = ST_IDLE;
              abort_nx = 1'b0;
            end else begin
              rinse_nx       = done_cnt;
              after_rinse_nx = 1'b0;
              state_nx       = (done_cnt >= tgt_q) ? ST_SPIN : ST_FILL;
            end
          end
        end
        ST_COMPLETE: if (!sig_door_closed) state_nx = ST_IDLE;
        ST_ERROR: begin
          // Forced drain empties the drum before the machine returns to IDLE.
          if (sig_cancel_button && !raw_fault && sig_door_closed) begin
            state_nx = ST_DRAIN;
            abort_nx = 1'b1;
          end
        end
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  assign tmr_load = (state_nx != state_q);
  assign tmr_val  = phase_ticks(state_nx, mode_nx);

  wash_phase_timer #(.TIMER_W(TIMER_W)) u_timer (
    .clock    (clock),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .hold     (paused),
    .count    (ticks_left),
    .done     (tmr_done)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      start_prev    <= 1'b1;
      mode_q        <= MODE_NORMAL;
      tgt_q         <= '0;
      rinse_index   <= '0;
      wash_done_q   <= 1'b0;
      after_rinse_q <= 1'b0;
      abort_q       <= 1'b0;
      error_code    <= '0;
      complete      <= 1'b0;
      water_filling <= 1'b0;
      door_locked   <= 1'b0;
      motor_on      <= 1'b0;
      drain_pump    <= 1'b0;
    end else begin
      state_q       <= state_nx;
      start_prev    <= sig_start_button;
      mode_q        <= mode_nx;
      tgt_q         <= tgt_nx;
      rinse_index   <= rinse_nx;
      wash_done_q   <= wash_done_nx;
      after_rinse_q <= after_rinse_nx;
      abort_q       <= abort_nx;
      error_code    <= err_nx;
      complete      <= (state_nx == ST_COMPLETE);
      water_filling <= (state_nx == ST_FILL) && !paused;
      door_locked   <= state_nx inside {ST_FILL, ST_WASH, ST_RINSE, ST_SPIN, ST_DRAIN};
      motor_on      <= (state_nx inside {ST_WASH, ST_RINSE, ST_SPIN}) && !paused;
      drain_pump    <= (state_nx == ST_DRAIN) && !paused;
    end
  end

  assign state = state_q;

endmodule
